// File: rtl/dfd_pkg.sv
// rtl/dfd_pkg.sv - shared DFD APB widths, arbiter state type and defaults
package dfd_pkg;

    localparam int DFD_APB_ADDR_WIDTH          = 23;
    localparam int DFD_APB_DATA_WIDTH          = 32;
    localparam int DFD_APB_PSTRB_WIDTH         = 4;
    localparam int DFD_APB_ARB_TIMEOUT_DEFAULT = 256;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_SETUP,
        ARB_ACCESS
    } dfd_apb_arb_state_e;

    // Index width that stays at least one bit for single-entry arbiters
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dfd_rr_arbiter.sv
// rtl/dfd_rr_arbiter.sv - round-robin arbiter; pointer advances past the winner on update
module dfd_rr_arbiter
    import dfd_pkg::*;
#(
    parameter int N = 2,
    localparam int IDX_W = idx_width(N)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [N-1:0]     req,
    input  logic             update,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             any
);

    logic [IDX_W-1:0] ptr;
    int               j;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        j         = 0;
        for (int k = 0; k < N; k++) begin
            j = (int'(ptr) + k) % N;
            if (!any && req[j]) begin
                any       = 1'b1;
                grant[j]  = 1'b1;
                grant_idx = IDX_W'(j);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr <= '0;
        end else if (update) begin
            ptr <= (int'(grant_idx) == N - 1) ? '0 : IDX_W'(int'(grant_idx) + 1);
        end
    end

endmodule

// File: rtl/dfd_apb_arbiter.sv
// rtl/dfd_apb_arbiter.sv - round-robin share of the DFD MMR APB port with access timeout
module dfd_apb_arbiter
    import dfd_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int ADDR_W         = DFD_APB_ADDR_WIDTH,
    parameter int DATA_W         = DFD_APB_DATA_WIDTH,
    parameter int STRB_W         = DFD_APB_PSTRB_WIDTH,
    parameter int TIMEOUT_CYCLES = DFD_APB_ARB_TIMEOUT_DEFAULT,
    localparam int IDX_W = idx_width(NUM_REQ)
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [NUM_REQ-1:0]         i_req_valid,
    output logic [NUM_REQ-1:0]         o_req_ready,
    input  logic [NUM_REQ*ADDR_W-1:0]  i_req_addr,
    input  logic [NUM_REQ-1:0]         i_req_write,
    input  logic [NUM_REQ*DATA_W-1:0]  i_req_wdata,
    input  logic [NUM_REQ*STRB_W-1:0]  i_req_strb,
    output logic [NUM_REQ-1:0]         o_rsp_valid,
    output logic [DATA_W-1:0]          o_rsp_rdata,
    output logic                       o_rsp_err,
    output logic                       o_busy,
    output logic [IDX_W-1:0]           o_grant_id,
    output logic [ADDR_W-1:0]          paddr,
    output logic                       psel,
    output logic                       penable,
    output logic [STRB_W-1:0]          pstrb,
    output logic                       pwrite,
    output logic [DATA_W-1:0]          pwdata,
    input  logic                       pready,
    input  logic [DATA_W-1:0]          prdata,
    input  logic                       pslverr
);

    // Counter only needs to reach TIMEOUT_CYCLES-1; it saturates at all-ones
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    dfd_apb_arb_state_e state, next_state;
    logic [CNT_W-1:0]   cnt;
    logic [NUM_REQ-1:0] grant;
    logic [IDX_W-1:0]   grant_idx;
    logic               any;
    logic               accept;
    logic               timeout_hit;
    logic               done;
    int                 sel;

    dfd_rr_arbiter #(.N(NUM_REQ)) u_rr (
        .clk       (clk),
        .reset_n   (reset_n),
        .req       (i_req_valid),
        .update    (accept),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any       (any)
    );

    assign sel         = int'(grant_idx);
    assign accept      = (state == ARB_IDLE) && any;
    assign o_req_ready = (state == ARB_IDLE) ? grant : '0;
    assign o_busy      = (state != ARB_IDLE);
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (int'(cnt) == TIMEOUT_CYCLES - 1);
    assign done        = (state == ARB_ACCESS) && (pready || timeout_hit);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ARB_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            ARB_IDLE:   if (any) next_state = ARB_SETUP;
            ARB_SETUP:  next_state = ARB_ACCESS;
            ARB_ACCESS: if (done) next_state = ARB_IDLE;
            default:    next_state = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            paddr       <= '0;
            pwrite      <= 1'b0;
            pwdata      <= '0;
            pstrb       <= '0;
            psel        <= 1'b0;
            penable     <= 1'b0;
            cnt         <= '0;
            o_grant_id  <= '0;
            o_rsp_valid <= '0;
            o_rsp_rdata <= '0;
            o_rsp_err   <= 1'b0;
        end else begin
            o_rsp_valid <= '0;
            unique case (state)
                ARB_IDLE: begin
                    if (accept) begin
                        paddr      <= i_req_addr[sel*ADDR_W +: ADDR_W];
                        pwrite     <= i_req_write[sel];
                        pwdata     <= i_req_wdata[sel*DATA_W +: DATA_W];
                        pstrb      <= i_req_strb[sel*STRB_W +: STRB_W];
                        psel       <= 1'b1;
                        penable    <= 1'b0;
                        o_grant_id <= grant_idx;
                    end
                end
                ARB_SETUP: begin
                    penable <= 1'b1;
                    cnt     <= '0;
                end
                ARB_ACCESS: begin
                    if (done) begin
                        psel        <= 1'b0;
                        penable     <= 1'b0;
                        o_rsp_valid <= NUM_REQ'(1) << o_grant_id;
                        // A real pready wins over a coincident timeout
                        o_rsp_rdata <= (pready && !pwrite) ? prdata : '0;
                        o_rsp_err   <= pready ? pslverr : 1'b1;
                    end else if (cnt != '1) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_req_chk
        a_valid_held: assert property (@(posedge clk) disable iff (!reset_n)
            (i_req_valid[g] && !o_req_ready[g]) |=> i_req_valid[g]);
    end

endmodule
